// File: rtl/axi_lite_pkg.sv
// Shared response codes and FSM state encodings for the AXI-lite SRAM responder.
package axi_lite_pkg;

  localparam logic [2:0] OKAY   = 3'b000;
  localparam logic [2:0] SLVERR = 3'b010;
  localparam logic [2:0] DECERR = 3'b011;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_t;

  typedef enum logic [2:0] {
    W_IDLE    = 3'd0,
    W_WAIT_W  = 3'd1,
    W_WAIT_AW = 3'd2,
    W_DELAY   = 3'd3,
    W_RESP    = 3'd4
  } wr_state_t;

endpackage

// File: rtl/sram_byte_array.sv
// Word-organised storage with one registered read port and one byte-masked
// write port; a same-edge read of the written word returns the old contents.
module sram_byte_array #(
  parameter int DATA_LEN     = 32,
  parameter int DATA_BIT_NUM = 4,
  parameter int MEM_DEPTH    = 1024,
  parameter int IDX_W        = $clog2(MEM_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rd_en,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [DATA_LEN-1:0]     rd_data,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [DATA_BIT_NUM-1:0] wr_strb,
  input  logic [DATA_LEN-1:0]     wr_data
);

  logic [DATA_LEN-1:0] mem [MEM_DEPTH];

  // Registered read on enable and per-lane write; both non-blocking, so a
  // collision on the same edge reads the pre-write word.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_idx];
    for (int i = 0; i < DATA_BIT_NUM; i++) begin
      if (wr_en && wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI-lite style memory responder: independent read and write FSMs with
// programmable response latency in front of a byte-writable SRAM model.
module axi_sram_slave
  import axi_lite_pkg::*;
#(
  parameter int                 DATA_LEN     = 32,
  parameter int                 DATA_BIT_NUM = 4,
  parameter logic [DATA_LEN-1:0] ADDR_BASE   = 32'h8000_0000,
  parameter int                 MEM_DEPTH    = 1024,
  parameter int                 RD_LATENCY   = 1,
  parameter int                 WR_LATENCY   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_LEN-1:0]     waddr,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [DATA_BIT_NUM-1:0] wstrob,
  input  logic [DATA_LEN-1:0]     wdata,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [2:0]              bresp,
  input  logic                    arvalid,
  output logic                    arready,
  input  logic [DATA_LEN-1:0]     raddr,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [2:0]              rresp,
  output logic [DATA_LEN-1:0]     rdata
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  function automatic logic in_range(input logic [DATA_LEN-1:0] a);
    return (a >= ADDR_BASE) && ((a - ADDR_BASE) < DATA_LEN'(4 * MEM_DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [DATA_LEN-1:0] a);
    return IDX_W'((a - ADDR_BASE) >> 2);
  endfunction

  rd_state_t r_state, r_state_nxt;
  logic [3:0] r_cnt, r_cnt_nxt;
  logic [2:0] rresp_q;
  logic       r_ok_q;
  logic       ar_hs, ar_in;

  wr_state_t w_state, w_state_nxt;
  logic [3:0]              w_cnt, w_cnt_nxt;
  logic [2:0]              bresp_q;
  logic [DATA_LEN-1:0]     awaddr_q, wdata_q;
  logic [DATA_BIT_NUM-1:0] wstrb_q;
  logic                    aw_hs, w_hs, commit, c_in;
  logic [DATA_LEN-1:0]     c_addr, c_data;
  logic [DATA_BIT_NUM-1:0] c_strb;
  logic [DATA_LEN-1:0]     ram_q;

  assign ar_hs = (r_state == R_IDLE) && arvalid;
  assign ar_in = in_range(raddr);
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign c_in  = in_range(c_addr);

  assign arready = (r_state == R_IDLE);
  assign rvalid  = (r_state == R_RESP);
  assign rresp   = rresp_q;
  assign rdata   = r_ok_q ? ram_q : '0;

  assign awready = (w_state == W_IDLE) || (w_state == W_WAIT_AW);
  assign wready  = (w_state == W_IDLE) || (w_state == W_WAIT_W);
  assign bvalid  = (w_state == W_RESP);
  assign bresp   = bresp_q;

  sram_byte_array #(
    .DATA_LEN(DATA_LEN), .DATA_BIT_NUM(DATA_BIT_NUM), .MEM_DEPTH(MEM_DEPTH), .IDX_W(IDX_W)
  ) u_array (
    .clk     (clk),
    .rd_en   (ar_hs && ar_in),
    .rd_idx  (word_idx(raddr)),
    .rd_data (ram_q),
    .wr_en   (commit && c_in && !rst),
    .wr_idx  (word_idx(c_addr)),
    .wr_strb (c_strb),
    .wr_data (c_data)
  );

  // Read FSM next state: accept, count down the latency, hold until rready.
  always_comb begin
    r_state_nxt = r_state;
    r_cnt_nxt   = r_cnt;
    case (r_state)
      R_IDLE: if (arvalid) begin
        r_cnt_nxt   = 4'(RD_LATENCY - 1);
        r_state_nxt = (RD_LATENCY == 1) ? R_RESP : R_WAIT;
      end
      R_WAIT: if (r_cnt == 4'd0) r_state_nxt = R_RESP;
              else r_cnt_nxt = r_cnt - 4'd1;
      R_RESP: if (rready) r_state_nxt = R_IDLE;
      default: begin
        r_state_nxt = R_IDLE;
        r_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Read FSM state, counter and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_cnt   <= 4'd0;
      rresp_q <= OKAY;
      r_ok_q  <= 1'b0;
    end else begin
      r_state <= r_state_nxt;
      r_cnt   <= r_cnt_nxt;
      if (ar_hs) begin
        rresp_q <= ar_in ? OKAY : DECERR;
        r_ok_q  <= ar_in;
      end
    end
  end

  // Write FSM next state and commit selection: a half-captured request uses
  // the stored channel together with the live one.
  always_comb begin
    w_state_nxt = w_state;
    w_cnt_nxt   = w_cnt;
    commit      = 1'b0;
    c_addr      = waddr;
    c_data      = wdata;
    c_strb      = wstrob;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) commit = 1'b1;
        else if (aw_hs)    w_state_nxt = W_WAIT_W;
        else if (w_hs)     w_state_nxt = W_WAIT_AW;
      end
      W_WAIT_W: begin
        c_addr = awaddr_q;
        commit = wvalid;
      end
      W_WAIT_AW: begin
        c_data = wdata_q;
        c_strb = wstrb_q;
        commit = awvalid;
      end
      W_DELAY: if (w_cnt == 4'd0) w_state_nxt = W_RESP;
               else w_cnt_nxt = w_cnt - 4'd1;
      W_RESP: if (bready) w_state_nxt = W_IDLE;
      default: begin
        w_state_nxt = W_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
    if (commit) begin
      w_cnt_nxt   = 4'(WR_LATENCY - 1);
      w_state_nxt = (WR_LATENCY == 1) ? W_RESP : W_DELAY;
    end
  end

  // Write FSM state, counter and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      w_cnt   <= 4'd0;
      bresp_q <= OKAY;
    end else begin
      w_state <= w_state_nxt;
      w_cnt   <= w_cnt_nxt;
      if (commit) bresp_q <= c_in ? OKAY : DECERR;
    end
  end

  // Hold whichever write channel arrived first.
  always_ff @(posedge clk) begin
    if (aw_hs) awaddr_q <= waddr;
    if (w_hs) begin
      wdata_q <= wdata;
      wstrb_q <= wstrob;
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Bench for axi_sram_slave: table of write/read pairs plus hand sequences for
// split handshakes, long read latency, same-edge collision and mid-flight reset.
module tb_axi_sram_slave;
  import axi_lite_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] waddr, wdata, raddr;
  logic [3:0]  wstrob;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [2:0]  bresp, rresp;
  logic [31:0] rdata;

  logic        arvalid4, rready4;
  logic [31:0] raddr4;
  logic        awready4, wready4, bvalid4, arready4, rvalid4;
  logic [2:0]  bresp4, rresp4;
  logic [31:0] rdata4;

  always #5 clk = ~clk;

  axi_sram_slave dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .waddr(waddr),
    .wvalid(wvalid), .wready(wready), .wstrob(wstrob), .wdata(wdata),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .raddr(raddr),
    .rvalid(rvalid), .rready(rready), .rresp(rresp), .rdata(rdata)
  );

  axi_sram_slave #(.RD_LATENCY(4), .WR_LATENCY(1)) dut4 (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready4), .waddr(waddr),
    .wvalid(wvalid), .wready(wready4), .wstrob(wstrob), .wdata(wdata),
    .bvalid(bvalid4), .bready(bready), .bresp(bresp4),
    .arvalid(arvalid4), .arready(arready4), .raddr(raddr4),
    .rvalid(rvalid4), .rready(rready4), .rresp(rresp4), .rdata(rdata4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  resp;
  } rexp_t;

  rexp_t      rq[$];
  logic [2:0] bq[$];

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  bresp;
    logic [31:0] raddr;
    logic [31:0] rdata;
    logic [2:0]  rresp;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called #1 after the commit edge.
  task automatic wait_b(input int exp_lat, input string nm);
    int lat = 1;
    logic [2:0] e;
    while (!bvalid && lat < 30) begin
      tick;
      lat++;
    end
    check({nm, "_blat"}, lat, exp_lat);
    e = (bq.size() > 0) ? bq.pop_front() : 3'b111;
    if (bvalid) begin
      check({nm, "_bresp"}, {29'd0, bresp}, {29'd0, e});
      bready = 1'b1;
      tick;
      bready = 1'b0;
      check({nm, "_bdrop"}, {31'd0, bvalid}, 32'd0);
    end
  endtask

  // Called #1 after the AR handshake edge.
  task automatic wait_r(input int exp_lat, input string nm);
    int lat = 1;
    rexp_t e;
    while (!rvalid && lat < 30) begin
      tick;
      lat++;
    end
    check({nm, "_rlat"}, lat, exp_lat);
    if (rq.size() > 0) e = rq.pop_front();
    else begin
      e.data = 32'hxxxx_xxxx;
      e.resp = 3'b111;
    end
    if (rvalid) begin
      check({nm, "_rdata"}, rdata, e.data);
      check({nm, "_rresp"}, {29'd0, rresp}, {29'd0, e.resp});
      rready = 1'b1;
      tick;
      rready = 1'b0;
      check({nm, "_rdrop"}, {31'd0, rvalid}, 32'd0);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [2:0] resp, input string nm);
    awvalid = 1'b1; wvalid = 1'b1; waddr = a; wdata = d; wstrob = s;
    bq.push_back(resp);
    tick;
    awvalid = 1'b0; wvalid = 1'b0;
    wait_b(1, nm);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] d, input logic [2:0] resp,
                         input string nm);
    rexp_t e;
    e.data = d;
    e.resp = resp;
    arvalid = 1'b1; raddr = a;
    rq.push_back(e);
    tick;
    arvalid = 1'b0;
    wait_r(1, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{32'h8000_0000, 32'h0101_0101, 4'hF, OKAY,   32'h8000_0000, 32'h0101_0101, OKAY};
    tbl[1]  = '{32'h8000_0004, 32'hDEAD_BEEF, 4'hF, OKAY,   32'h8000_0004, 32'hDEAD_BEEF, OKAY};
    tbl[2]  = '{32'h8000_0008, 32'h1122_3344, 4'hF, OKAY,   32'h8000_0008, 32'h1122_3344, OKAY};
    tbl[3]  = '{32'h8000_0008, 32'hAABB_CCDD, 4'h5, OKAY,   32'h8000_0008, 32'h11BB_33DD, OKAY};
    tbl[4]  = '{32'h8000_000A, 32'hFFFF_FFFF, 4'h0, OKAY,   32'h8000_0008, 32'h11BB_33DD, OKAY};
    tbl[5]  = '{32'h8000_000E, 32'h7654_3210, 4'hF, OKAY,   32'h8000_000C, 32'h7654_3210, OKAY};
    tbl[6]  = '{32'h8000_0FFC, 32'hCAFE_F00D, 4'hF, OKAY,   32'h8000_0FFF, 32'hCAFE_F00D, OKAY};
    tbl[7]  = '{32'h8000_1000, 32'hFFFF_FFFF, 4'hF, DECERR, 32'h8000_0000, 32'h0101_0101, OKAY};
    tbl[8]  = '{32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, DECERR, 32'h7FFF_FFFC, 32'h0000_0000, DECERR};
    tbl[9]  = '{32'h8000_0010, 32'h0000_0000, 4'hF, OKAY,   32'h8000_1000, 32'h0000_0000, DECERR};
    tbl[10] = '{32'h8000_0014, 32'h0000_0000, 4'hF, OKAY,   32'h8000_0014, 32'h0000_0000, OKAY};

    rst = 1'b1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    waddr = '0; wdata = '0; raddr = '0; wstrob = '0;
    arvalid4 = 1'b0; rready4 = 1'b0; raddr4 = '0;
    tick;
    tick;
    rst = 1'b0;

    check("rst_readies", {29'd0, awready, wready, arready}, 32'd7);
    check("rst_valids", {30'd0, bvalid, rvalid}, 32'd0);
    check("rst_bresp", {29'd0, bresp}, 32'd0);
    check("rst_rresp", {29'd0, rresp}, 32'd0);
    check("rst_rdata", rdata, 32'd0);

    for (int i = 0; i < 11; i++) begin
      do_write(tbl[i].waddr, tbl[i].wdata, tbl[i].strb, tbl[i].bresp, $sformatf("vec%0d_w", i));
      do_read(tbl[i].raddr, tbl[i].rdata, tbl[i].rresp, $sformatf("vec%0d_r", i));
    end

    // W channel three edges ahead of AW; bus data changes before AW arrives.
    wvalid = 1'b1; waddr = 32'h0; wdata = 32'h1234_0000; wstrob = 4'b1100;
    bq.push_back(OKAY);
    tick;
    wvalid = 1'b0; wdata = 32'hFFFF_FFFF; wstrob = 4'hF;
    check("split_wready0", {31'd0, wready}, 32'd0);
    check("split_awready0", {31'd0, awready}, 32'd1);
    tick;
    check("split_wready1", {31'd0, wready}, 32'd0);
    check("split_nob1", {31'd0, bvalid}, 32'd0);
    tick;
    check("split_wready2", {31'd0, wready}, 32'd0);
    awvalid = 1'b1; waddr = 32'h8000_0006;
    tick;
    awvalid = 1'b0;
    wait_b(1, "split");
    do_read(32'h8000_0004, 32'h1234_BEEF, OKAY, "split_rd");

    // Four-cycle read latency with rready held off.
    arvalid4 = 1'b1; raddr4 = 32'h8000_0004;
    tick;
    arvalid4 = 1'b0;
    check("lat4_arready", {31'd0, arready4}, 32'd0);
    begin
      int lat = 0;
      while (!rvalid4 && lat < 30) begin
        tick;
        lat++;
      end
      check("lat4_edges", lat, 32'd4);
    end
    for (int k = 0; k < 5; k++) begin
      check($sformatf("lat4_hold%0d_v", k), {31'd0, rvalid4}, 32'd1);
      check($sformatf("lat4_hold%0d_d", k), rdata4, 32'h1234_BEEF);
      check($sformatf("lat4_hold%0d_r", k), {29'd0, rresp4}, {29'd0, OKAY});
      tick;
    end
    rready4 = 1'b1;
    tick;
    rready4 = 1'b0;
    check("lat4_drop", {30'd0, rvalid4, arready4}, 32'd1);

    // AR handshake on the same edge as a write commit to the same word.
    begin
      rexp_t e;
      e.data = 32'h0;
      e.resp = OKAY;
      awvalid = 1'b1; wvalid = 1'b1; waddr = 32'h8000_0010; wdata = 32'h5555_5555; wstrob = 4'hF;
      arvalid = 1'b1; raddr = 32'h8000_0010;
      bq.push_back(OKAY);
      rq.push_back(e);
      tick;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      wait_b(1, "coll_w");
      wait_r(1, "coll_r");
    end
    do_read(32'h8000_0010, 32'h5555_5555, OKAY, "coll_after");

    // Reset with a write waiting for W and a long read counting down.
    awvalid = 1'b1; waddr = 32'h8000_0014;
    arvalid4 = 1'b1; raddr4 = 32'h8000_0014;
    tick;
    awvalid = 1'b0; arvalid4 = 1'b0;
    check("mid_wait_w", {30'd0, awready, wready}, 32'd1);
    check("mid_r_wait", {30'd0, arready4, rvalid4}, 32'd0);
    wvalid = 1'b1; wdata = 32'hFFFF_FFFF; wstrob = 4'hF; rst = 1'b1;
    tick;
    rst = 1'b0; wvalid = 1'b0;
    check("mid_rst_valids", {28'd0, bvalid, rvalid, bvalid4, rvalid4}, 32'd0);
    check("mid_rst_ready", {29'd0, awready, wready, arready}, 32'd7);
    check("mid_rst_ready4", {29'd0, awready4, wready4, arready4}, 32'd7);
    check("mid_rst_resp4", {26'd0, bresp4, rresp4}, 32'd0);
    do_read(32'h8000_0014, 32'h0000_0000, OKAY, "mid_rst_rd");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
